id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage RV32I pipeline. It sits between the IF/ID latch and EX.
- Drives the register-file read addresses and receives the read data. It bypasses same-cycle writeback data, generates immediates and control, and detects load-use hazards.
- Holds the ID/EX pipeline register. Supports stall (bubble insertion) and flush.

---
 rtl/id_stage.sv | 195 +++++++++++++++++++
 tb/tb_id_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage RV32I pipeline.
// Decodes the IF/ID instruction, bypasses same-cycle writeback data into the operands,
// detects load-use hazards and holds the ID/EX pipeline register.
module id_stage #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_flush,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_alt,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal,
  output logic [31:0]     stall_count
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic            uses_rs1, uses_rs2;
  logic            dec_reg_write, dec_mem_read, dec_mem_write;
  logic            dec_branch, dec_jump, dec_illegal, dec_alt;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            load_use;
  logic            load_slot;

  assign opcode      = if_instr[6:0];
  assign funct3      = if_instr[14:12];
  assign rs1         = if_instr[19:15];
  assign rs2         = if_instr[24:20];
  assign rd          = if_instr[11:7];
  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  // The register file writes at the clock edge, so a same-cycle writeback must be forwarded.
  assign rs1_val = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1)) ? wb_data : rf_rs1_data;
  assign rs2_val = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2)) ? wb_data : rf_rs2_data;

  // Opcode decode: control bits, operand usage and immediate format.
  always_comb begin
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_illegal   = 1'b0;
    dec_alt       = 1'b0;
    dec_imm       = '0;
    case (opcode)
      OpcOp: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec_reg_write = 1'b1;
        dec_alt       = if_instr[30];
      end
      OpcOpImm: begin
        uses_rs1      = 1'b1;
        dec_reg_write = 1'b1;
        dec_imm       = {{20{if_instr[31]}}, if_instr[31:20]};
        // Only SRAI carries a meaningful instr[30] among the immediate forms.
        dec_alt       = (funct3 == 3'b101) && if_instr[30];
      end
      OpcLoad: begin
        uses_rs1      = 1'b1;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_imm       = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OpcStore: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec_mem_write = 1'b1;
        dec_imm       = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      end
      OpcBranch: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        dec_branch = 1'b1;
        dec_imm    = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
      end
      OpcJal: begin
        dec_reg_write = 1'b1;
        dec_jump      = 1'b1;
        dec_imm       = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20],
                         if_instr[30:21], 1'b0};
      end
      OpcJalr: begin
        uses_rs1      = 1'b1;
        dec_reg_write = 1'b1;
        dec_jump      = 1'b1;
        dec_imm       = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OpcLui, OpcAuipc: begin
        dec_reg_write = 1'b1;
        dec_imm       = {if_instr[31:12], 12'b0};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && if_valid &&
                    ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
  assign id_stall = load_use && !ex_flush;
  // Flush and stall both turn the slot into a bubble with all control bits clear.
  assign load_slot = if_valid && !ex_flush && !id_stall;

  // ID/EX pipeline register; data fields load every cycle, control only for a live slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= RESET_PC;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_alt       <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_illegal   <= 1'b0;
    end else begin
      ex_valid     <= load_slot;
      ex_pc        <= if_pc;
      ex_rs1_val   <= rs1_val;
      ex_rs2_val   <= rs2_val;
      ex_imm       <= dec_imm;
      ex_rs1       <= rs1;
      ex_rs2       <= rs2;
      ex_rd        <= rd;
      ex_opcode    <= opcode;
      ex_funct3    <= funct3;
      ex_alt       <= load_slot && dec_alt;
      ex_reg_write <= load_slot && dec_reg_write;
      ex_mem_read  <= load_slot && dec_mem_read;
      ex_mem_write <= load_slot && dec_mem_write;
      ex_branch    <= load_slot && dec_branch;
      ex_jump      <= load_slot && dec_jump;
      ex_illegal   <= load_slot && dec_illegal;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (id_stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a vector table plus hand-written hazard and reset sequences,
// with expected ID/EX contents queued at drive time and compared after the clock edge.
module tb_id_stage;

  localparam logic [31:0] ResetPc = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        id_stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_alt, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal;
  logic [31:0] stall_count;

  id_stage #(.XLEN(32), .RESET_PC(ResetPc)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_alt(ex_alt), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_illegal(ex_illegal), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // ctl packing: {reg_write, mem_read, mem_write, branch, jump, illegal, alt}
  typedef struct {
    logic [31:0] instr, pc, rs1d;
    logic        valid, wbwe, flush;
    logic [4:0]  wbrd;
    logic [31:0] wbdata;
    logic        stall;
    logic        e_valid;
    logic [6:0]  ctl;
    logic        ck_imm;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic [31:0] e_rs1v, e_rs2v;
  } vec_t;

  localparam logic [31:0] Rs2d = 32'h0000_0022;

  int   checks = 0;
  int   errors = 0;
  int   sc_model = 0;
  vec_t sb[$];
  vec_t vecs[$];
  logic [31:0] pc_ctr = 32'h0000_0100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic valid, input logic [31:0] rs1d,
                              input logic wbwe, input logic [4:0] wbrd, input logic [31:0] wbdata,
                              input logic flush, input logic stall, input logic e_valid,
                              input logic [6:0] ctl, input logic ck_imm, input logic [31:0] e_imm,
                              input logic [4:0] e_rd, input logic [31:0] e_rs1v,
                              input logic [31:0] e_rs2v);
    vec_t v;
    v.instr = instr;   v.pc = 32'h0;     v.rs1d = rs1d;   v.valid = valid;
    v.wbwe = wbwe;     v.wbrd = wbrd;    v.wbdata = wbdata; v.flush = flush;
    v.stall = stall;   v.e_valid = e_valid; v.ctl = ctl; v.ck_imm = ck_imm;
    v.e_imm = e_imm;   v.e_rd = e_rd;    v.e_rs1v = e_rs1v; v.e_rs2v = e_rs2v;
    return v;
  endfunction

  // Drive one instruction at the falling edge, check id_stall, then check ID/EX after the edge.
  task automatic run(input vec_t vin);
    vec_t v;
    vec_t e;
    v = vin;
    v.pc = pc_ctr;
    pc_ctr += 32'd4;
    @(negedge clk);
    if_instr = v.instr; if_pc = v.pc; if_valid = v.valid;
    rf_rs1_data = v.rs1d; rf_rs2_data = Rs2d;
    wb_we = v.wbwe; wb_rd = v.wbrd; wb_data = v.wbdata; ex_flush = v.flush;
    #1;
    chk("id_stall", {31'b0, id_stall}, {31'b0, v.stall});
    if (v.stall) sc_model++;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("ex_valid", {31'b0, ex_valid}, {31'b0, e.e_valid});
      chk("ex_ctl", {25'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump,
                     ex_illegal, ex_alt}, {25'b0, e.ctl});
      if (e.e_valid) begin
        if (e.ck_imm) chk("ex_imm", ex_imm, e.e_imm);
        chk("ex_rd", {27'b0, ex_rd}, {27'b0, e.e_rd});
        chk("ex_rs1_val", ex_rs1_val, e.e_rs1v);
        chk("ex_rs2_val", ex_rs2_val, e.e_rs2v);
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_opcode", {25'b0, ex_opcode}, {25'b0, e.instr[6:0]});
        chk("ex_funct3", {29'b0, ex_funct3}, {29'b0, e.instr[14:12]});
      end
      chk("stall_count", stall_count, sc_model);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
    rf_rs1_data = 32'h0; rf_rs2_data = 32'h0; wb_we = 1'b0; wb_rd = 5'd0;
    wb_data = 32'h0; ex_flush = 1'b0;
    #3;
    chk("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("reset_ex_pc", ex_pc, ResetPc);
    chk("reset_stall_count", stall_count, 32'd0);
    chk("reset_id_stall", {31'b0, id_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //             instr          v  rs1d   we rd  wbdata  fl st ev ctl        ck imm            rd  rs1v   rs2v
    vecs.push_back(mk(32'hFFF00093, 1, 32'h0,  0, 0, 32'h0,    0, 0, 1, 7'b1000000, 1, 32'hFFFFFFFF, 1, 32'h0,  Rs2d));
    vecs.push_back(mk(32'hFFDFF06F, 1, 32'h33, 0, 0, 32'h0,    0, 0, 1, 7'b1000100, 1, 32'hFFFFFFFC, 0, 32'h33, Rs2d));
    vecs.push_back(mk(32'h00028313, 1, 32'h11, 1, 5, 32'hABCD, 0, 0, 1, 7'b1000000, 1, 32'h0,        6, 32'hABCD, Rs2d));
    vecs.push_back(mk(32'h00000313, 1, 32'h11, 1, 0, 32'hABCD, 0, 0, 1, 7'b1000000, 1, 32'h0,        6, 32'h11, Rs2d));
    vecs.push_back(mk(32'h00028313, 1, 32'h11, 0, 5, 32'hABCD, 0, 0, 1, 7'b1000000, 1, 32'h0,        6, 32'h11, Rs2d));
    vecs.push_back(mk(32'h402081B3, 1, 32'h44, 1, 2, 32'h5555, 0, 0, 1, 7'b1000001, 0, 32'h0,        3, 32'h44, 32'h5555));
    vecs.push_back(mk(32'h4030D093, 1, 32'h44, 0, 0, 32'h0,    0, 0, 1, 7'b1000001, 1, 32'h403,      1, 32'h44, Rs2d));
    vecs.push_back(mk(32'hFE20AC23, 1, 32'h0,  0, 0, 32'h0,    0, 0, 1, 7'b0010000, 1, 32'hFFFFFFF8, 24, 32'h0, Rs2d));
    vecs.push_back(mk(32'h00208463, 1, 32'h0,  0, 0, 32'h0,    0, 0, 1, 7'b0001000, 1, 32'h8,        8, 32'h0,  Rs2d));
    vecs.push_back(mk(32'hFE000FE3, 1, 32'h0,  0, 0, 32'h0,    0, 0, 1, 7'b0001000, 1, 32'hFFFFFFFE, 31, 32'h0, Rs2d));
    vecs.push_back(mk(32'h123452B7, 1, 32'h0,  0, 0, 32'h0,    0, 0, 1, 7'b1000000, 1, 32'h12345000, 5, 32'h0,  Rs2d));
    vecs.push_back(mk(32'h80000097, 1, 32'h0,  0, 0, 32'h0,    0, 0, 1, 7'b1000000, 1, 32'h80000000, 1, 32'h0,  Rs2d));
    vecs.push_back(mk(32'h010100E7, 1, 32'h0,  0, 0, 32'h0,    0, 0, 1, 7'b1000100, 1, 32'h10,       1, 32'h0,  Rs2d));
    vecs.push_back(mk(32'h0000007F, 1, 32'h0,  0, 0, 32'h0,    0, 0, 1, 7'b0000010, 0, 32'h0,        0, 32'h0,  Rs2d));
    vecs.push_back(mk(32'hFFF00093, 0, 32'h0,  0, 0, 32'h0,    0, 0, 0, 7'b0000000, 0, 32'h0,        0, 32'h0,  Rs2d));
    vecs.push_back(mk(32'h00012183, 1, 32'h0,  0, 0, 32'h0,    0, 0, 1, 7'b1100000, 1, 32'h0,        3, 32'h0,  Rs2d));
    // lui x3 whose rs1 field happens to be x3: not a register use, so no stall
    vecs.push_back(mk(32'h000181B7, 1, 32'h0,  0, 0, 32'h0,    0, 0, 1, 7'b1000000, 1, 32'h00018000, 3, 32'h0,  Rs2d));
    vecs.push_back(mk(32'h00118233, 1, 32'h77, 0, 0, 32'h0,    0, 0, 1, 7'b1000000, 0, 32'h0,        4, 32'h77, Rs2d));
    vecs.push_back(mk(32'h00012183, 1, 32'h0,  0, 0, 32'h0,    1, 0, 0, 7'b0000000, 0, 32'h0,        0, 32'h0,  Rs2d));

    foreach (vecs[i]) run(vecs[i]);

    // Load-use on rs1: one bubble, then the held add enters EX.
    run(mk(32'h00012183, 1, 32'h0,  0, 0, 32'h0, 0, 0, 1, 7'b1100000, 1, 32'h0, 3, 32'h0,  Rs2d));
    run(mk(32'h00118233, 1, 32'h77, 0, 0, 32'h0, 0, 1, 0, 7'b0000000, 0, 32'h0, 0, 32'h0,  Rs2d));
    run(mk(32'h00118233, 1, 32'h77, 0, 0, 32'h0, 0, 0, 1, 7'b1000000, 0, 32'h0, 4, 32'h77, Rs2d));
    // Load-use on rs2.
    run(mk(32'h00012183, 1, 32'h0,  0, 0, 32'h0, 0, 0, 1, 7'b1100000, 1, 32'h0, 3, 32'h0,  Rs2d));
    run(mk(32'h00308233, 1, 32'h5,  0, 0, 32'h0, 0, 1, 0, 7'b0000000, 0, 32'h0, 0, 32'h0,  Rs2d));
    run(mk(32'h00308233, 1, 32'h5,  0, 0, 32'h0, 0, 0, 1, 7'b1000000, 0, 32'h0, 4, 32'h5,  Rs2d));
    // Flush while the hazard is present: no stall, no count, empty slot.
    run(mk(32'h00012183, 1, 32'h0,  0, 0, 32'h0, 0, 0, 1, 7'b1100000, 1, 32'h0, 3, 32'h0,  Rs2d));
    run(mk(32'h00118233, 1, 32'h77, 0, 0, 32'h0, 1, 0, 0, 7'b0000000, 0, 32'h0, 0, 32'h0,  Rs2d));

    // Asynchronous reset mid-stream, sampled between clock edges.
    run(mk(32'h00012183, 1, 32'h0,  0, 0, 32'h0, 0, 0, 1, 7'b1100000, 1, 32'h0, 3, 32'h0,  Rs2d));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("async_rst_ex_pc", ex_pc, ResetPc);
    chk("async_rst_stall_count", stall_count, 32'd0);
    chk("async_rst_mem_read", {31'b0, ex_mem_read}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sc_model = 0;
    run(mk(32'hFFF00093, 1, 32'h0, 0, 0, 32'h0, 0, 0, 1, 7'b1000000, 1, 32'hFFFFFFFF, 1, 32'h0, Rs2d));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
